// File: rtl/video_timer_gen.sv
// Raster timing generator and frame-buffer address sequencer on clk8, phase-locked to busCycle.
// Optional sound fetch strobe built only when VIDEO_TIMER_SOUND_EN is defined.
`timescale 1ns/1ps
module video_timer_gen #(
  parameter int unsigned H_VISIBLE       = 128,
  parameter int unsigned H_TOTAL         = 168,
  parameter int unsigned H_SYNC_START    = 131,
  parameter int unsigned H_SYNC_END      = 147,
  parameter int unsigned V_VISIBLE_START = 42,
  parameter int unsigned V_VISIBLE_END   = 725,
  parameter int unsigned V_TOTAL         = 806,
  parameter int unsigned V_SYNC_START    = 771,
  parameter int unsigned V_SYNC_END      = 776,
  parameter int unsigned PIXEL_LATENCY   = 1,
  parameter bit          SYNC_POL        = 1'b0,
  parameter int unsigned ADDR_W          = 22,
  parameter int unsigned BYTES_PER_LINE  = 64,
  parameter logic [ADDR_W-1:0] BASE0     = 22'h3FA700,
  parameter logic [ADDR_W-1:0] BASE1     = 22'h3F2700
) (
  input  logic              clk8,
  input  logic              _reset,
  input  logic [1:0]        busCycle,
  input  logic              lineDouble,
  input  logic              pageSelect,
  output logic [ADDR_W-1:0] videoAddr,
  output logic              hsync,
  output logic              vsync,
  output logic              _hblank,
  output logic              _vblank,
  output logic              loadNormalPixels,
  output logic              loadDebugPixels,
  output logic              loadSound,
  output logic              vblankIrq,
  output logic [7:0]        frameCount,
  output logic              locked
);

  localparam int unsigned XW = $clog2(H_TOTAL);
  localparam int unsigned YW = $clog2(V_TOTAL);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_VIS  = XW'(H_VISIBLE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_SYNC_START + PIXEL_LATENCY);
  localparam logic [XW-1:0] X_HS1  = XW'(H_SYNC_END + PIXEL_LATENCY);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_VIS0 = YW'(V_VISIBLE_START);
  localparam logic [YW-1:0] Y_VIS1 = YW'(V_VISIBLE_END);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_SYNC_START);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_SYNC_END);

  logic [XW-1:0]     xpos_q, xpos_d;
  logic [YW-1:0]     ypos_q, ypos_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic              dbl_q, dbl_d;
  logic              wrap_q, wrap_d;
  logic              slip_q, slip_d;
  logic              locked_q, locked_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              irq_q, irq_d;
  logic [7:0]        frame_q, frame_d;

  logic hold, eol, vis_line, bus_zero;

  assign bus_zero = (busCycle == 2'd0);
  assign hold     = (xpos_q == '0) && !bus_zero;
  assign eol      = (xpos_q == X_LAST);
  assign vis_line = (ypos_q >= Y_VIS0) && (ypos_q <= Y_VIS1);

  always_comb begin
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    line_addr_d = line_addr_q;
    dbl_d       = dbl_q;
    wrap_d      = wrap_q;
    slip_d      = slip_q;
    locked_d    = locked_q;
    irq_d       = 1'b0;
    frame_d     = frame_q;

    if (eol) begin
      xpos_d = '0;
      ypos_d = (ypos_q == Y_LAST) ? '0 : ypos_q + YW'(1);
    end else if (!hold) begin
      xpos_d = xpos_q + XW'(1);
    end

    // Holds only count against lock once a line has wrapped; the post-reset
    // alignment holds are expected and must not delay the first lock.
    if (eol) begin
      wrap_d   = 1'b1;
      slip_d   = 1'b0;
      locked_d = !slip_q;
    end else if (hold && wrap_q) begin
      slip_d   = 1'b1;
      locked_d = 1'b0;
    end else if (xpos_q == '0) begin
      wrap_d = 1'b0;
    end

    if (eol && (ypos_q == Y_LAST)) begin
      line_addr_d = pageSelect ? BASE1 : BASE0;
      dbl_d       = 1'b0;
    end else if (eol && vis_line) begin
      if (!lineDouble) begin
        line_addr_d = line_addr_q + ADDR_W'(BYTES_PER_LINE);
      end else begin
        dbl_d = !dbl_q;
        if (dbl_q) line_addr_d = line_addr_q + ADDR_W'(BYTES_PER_LINE);
      end
    end

    if (eol && (ypos_q == Y_VIS1)) begin
      irq_d   = 1'b1;
      frame_d = frame_q + 8'd1;
    end

    hsync_d = ((xpos_q >= X_HS0) && (xpos_q <= X_HS1)) ? SYNC_POL : !SYNC_POL;
    vsync_d = ((ypos_q >= Y_VS0) && (ypos_q <= Y_VS1)) ? SYNC_POL : !SYNC_POL;
  end

  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) begin
      xpos_q      <= '0;
      ypos_q      <= '0;
      line_addr_q <= BASE0;
      dbl_q       <= 1'b0;
      wrap_q      <= 1'b0;
      slip_q      <= 1'b0;
      locked_q    <= 1'b0;
      hsync_q     <= !SYNC_POL;
      vsync_q     <= !SYNC_POL;
      irq_q       <= 1'b0;
      frame_q     <= '0;
    end else begin
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      line_addr_q <= line_addr_d;
      dbl_q       <= dbl_d;
      wrap_q      <= wrap_d;
      slip_q      <= slip_d;
      locked_q    <= locked_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      irq_q       <= irq_d;
      frame_q     <= frame_d;
    end
  end

  assign _hblank          = (xpos_q < X_VIS);
  assign _vblank          = vis_line;
  assign videoAddr        = line_addr_q + ADDR_W'({xpos_q[XW-1:2], 1'b0});
  assign loadNormalPixels = vis_line & _hblank & bus_zero;
  assign loadDebugPixels  = !vis_line & _hblank & bus_zero;
  assign hsync            = hsync_q;
  assign vsync            = vsync_q;
  assign vblankIrq        = irq_q;
  assign frameCount       = frame_q;
  assign locked           = locked_q;

`ifdef VIDEO_TIMER_SOUND_EN
  localparam logic [XW-1:0] X_SND = XW'(H_VISIBLE + 4);
  assign loadSound = (xpos_q == X_SND) && bus_zero;
`else
  assign loadSound = 1'b0;
`endif

endmodule
